// File: rtl/oam_dma_if.sv
// Bus bundle between the sprite DMA controller and the 6502 side.
// master: controller (drives rdy/mux/dma bus), slave: core/system side.
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw;
  logic [7:0]  bus_din;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_we;
  logic        dma_done;

  modport master (
    input  cpu_addr, cpu_dout, cpu_rw, bus_din,
    output cpu_rdy, dma_active, dma_addr,
    output dma_dout, dma_we, dma_done
  );

  modport slave (
    output cpu_addr, cpu_dout, cpu_rw, bus_din,
    input  cpu_rdy, dma_active, dma_addr,
    input  dma_dout, dma_we, dma_done
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: stalls the 6502, copies page {pg,00..FF} into OAM.
// Ports: clk, rst_n (sync, active low), bus (oam_dma_if.master).
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic       clk,
  input  logic       rst_n,
  oam_dma_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, HALT, ALIGN, READ, WRITE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        odd_q;
  logic        done_q, done_d;
  logic        rdy_q, rdy_d;
  logic        act_q, act_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;
  logic        we_q, we_d;

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.cpu_rw &&
            bus.cpu_addr == DMA_REG_ADDR) begin
          page_d  = bus.cpu_dout;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        // core only stalls on a read cycle
        if (bus.cpu_rw)
          state_d = odd_q ? READ : ALIGN;
      end
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus.bus_din;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from next state so they register with it
  always_comb begin
    rdy_d  = (state_d == IDLE);
    act_d  = 1'b0;
    addr_d = 16'h0000;
    dout_d = 8'h00;
    we_d   = 1'b0;
    unique case (1'b1)
      (state_d == READ): begin
        act_d  = 1'b1;
        addr_d = {page_d, idx_d};
      end
      (state_d == WRITE): begin
        act_d  = 1'b1;
        addr_d = OAM_DATA_ADDR;
        dout_d = data_d;
        we_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      odd_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      act_q   <= 1'b0;
      addr_q  <= 16'h0000;
      dout_q  <= 8'h00;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      odd_q   <= ~odd_q;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      we_q    <= we_d;
    end
  end

  assign bus.cpu_rdy    = rdy_q;
  assign bus.dma_active = act_q;
  assign bus.dma_addr   = addr_q;
  assign bus.dma_dout   = dout_q;
  assign bus.dma_we     = we_q;
  assign bus.dma_done   = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl.
// Memory model: bus_din = addr[7:0] ^ 8'h5A.
module tb_oam_dma_ctrl;

  logic clk;
  logic rst_n;
  logic par;
  int   total;
  int   bad;

  oam_dma_if bus ();

  oam_dma_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.bus_din = bus.dma_addr[7:0] ^ 8'h5A;

  // parity model: value of the cycle-parity flop
  always @(posedge clk)
    par <= rst_n ? ~par : 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, o, e);
    end
  endtask

  task automatic sync(input logic want);
    while (par !== want) step();
  endtask

  task automatic xfer(input logic [7:0] pg,
                      input int hold,
                      input bit inj,
                      input int x_stall,
                      input int x_pre,
                      input string tg);
    int stall, pre, nw, nr;
    int ea, ed, ep, early, k;
    bit fin;
    stall = 0; pre = 0; nw = 0; nr = 0;
    ea = 0; ed = 0; ep = 0; early = 0;
    k = 0; fin = 0;
    bus.cpu_addr = 16'h4014;
    bus.cpu_dout = pg;
    bus.cpu_rw   = 1'b0;
    step();
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    while (!fin && k < 2000) begin
      bus.cpu_rw = (k < hold) ? 1'b0 : 1'b1;
      if (!bus.cpu_rdy) begin
        stall++;
        if (bus.dma_done) early++;
        if (!bus.dma_active) begin
          pre++;
        end else if (!bus.dma_we) begin
          if (bus.dma_addr !== {pg, nr[7:0]})
            ea++;
          if (par !== 1'b0) ep++;
          nr++;
        end else begin
          if (bus.dma_addr !== 16'h2004) ed++;
          if (bus.dma_dout !== (nw[7:0] ^ 8'h5A))
            ed++;
          if (inj && nw == 16) begin
            bus.cpu_addr = 16'h4014;
            bus.cpu_dout = 8'h07;
            bus.cpu_rw   = 1'b0;
          end
          nw++;
        end
      end else begin
        fin = 1;
      end
      if (!fin) begin
        step();
        bus.cpu_addr = 16'h0000;
        bus.cpu_dout = 8'h00;
        k++;
      end
    end
    bus.cpu_rw = 1'b1;
    chk({tg, " finished"}, 32'(fin), 1);
    chk({tg, " stall"}, stall, x_stall);
    chk({tg, " halt+align"}, pre, x_pre);
    chk({tg, " nreads"}, nr, 256);
    chk({tg, " nwrites"}, nw, 256);
    chk({tg, " rd_addr_err"}, ea, 0);
    chk({tg, " wr_data_err"}, ed, 0);
    chk({tg, " rd_parity_err"}, ep, 0);
    chk({tg, " early_done"}, early, 0);
    chk({tg, " done_hi"}, 32'(bus.dma_done), 1);
    step();
    chk({tg, " done_lo"}, 32'(bus.dma_done), 0);
    chk({tg, " rdy_after"}, 32'(bus.cpu_rdy), 1);
  endtask

  initial begin
    int k, nw, ns;
    bit hit;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.cpu_rw   = 1'b1;
    step();
    step();
    chk("rst rdy", 32'(bus.cpu_rdy), 1);
    chk("rst act", 32'(bus.dma_active), 0);
    chk("rst addr", 32'(bus.dma_addr), 0);
    chk("rst dout", 32'(bus.dma_dout), 0);
    chk("rst we", 32'(bus.dma_we), 0);
    chk("rst done", 32'(bus.dma_done), 0);
    rst_n = 1'b1;
    step();
    step();

    // HALT on odd cycle: no ALIGN
    sync(1'b0);
    xfer(8'h02, 0, 0, 513, 1, "noalign");
    // HALT on even cycle: one ALIGN
    sync(1'b1);
    xfer(8'h02, 0, 0, 514, 2, "align");
    // two extra CPU write cycles in HALT
    sync(1'b0);
    xfer(8'h31, 2, 0, 515, 3, "hold2");
    // retrigger during WRITE idx=10 ignored
    sync(1'b0);
    xfer(8'h02, 0, 1, 513, 1, "retrig");

    // reset mid-transfer at READ idx=80
    bus.cpu_addr = 16'h4014;
    bus.cpu_dout = 8'h02;
    bus.cpu_rw   = 1'b0;
    step();
    bus.cpu_addr = 16'h0000;
    bus.cpu_dout = 8'h00;
    bus.cpu_rw   = 1'b1;
    hit = 0;
    k = 0;
    while (!hit && k < 1000) begin
      if (bus.dma_active && !bus.dma_we &&
          bus.dma_addr == 16'h0280)
        hit = 1;
      else begin
        step();
        k++;
      end
    end
    chk("mid found", 32'(hit), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid rdy", 32'(bus.cpu_rdy), 1);
    chk("mid act", 32'(bus.dma_active), 0);
    chk("mid we", 32'(bus.dma_we), 0);
    chk("mid done", 32'(bus.dma_done), 0);
    nw = 0;
    ns = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (bus.dma_we) nw++;
      if (!bus.cpu_rdy) ns++;
    end
    chk("post writes", nw, 0);
    chk("post stall", ns, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
